moving_avg_win: RTL and testbench

MOVING_AVG_WIN -- requirements
Module: moving_avg_win

---
 rtl/moving_avg_win.sv | 125 ++++++++++++
 tb/tb_moving_avg_win.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/moving_avg_win.sv
`default_nettype none
// ============================================================================
// Module   : moving_avg_win
// Brief    : Windowed moving average over the last 2^LOG2_N signed samples.
//            Optional macro MOVING_AVG_ROUND_EN selects round-half-up output.
// Revision : 1.0 - initial release
// ============================================================================
module moving_avg_win #(
    parameter int WL     = 32,
    parameter int LOG2_N = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 EN,
    input  logic                 clear,
    input  logic                 in_valid,
    input  logic signed [WL-1:0] data_in,
    output logic signed [WL-1:0] data_out,
    output logic                 out_valid,
    output logic                 win_full
);

    localparam int c_n  = 1 << LOG2_N;
    localparam int c_pw = (LOG2_N > 0) ? LOG2_N : 1;
    localparam int c_fw = LOG2_N + 1;
    localparam int c_sw = WL + LOG2_N;

    logic signed [WL-1:0]   buf_q [c_n];
    logic [c_pw-1:0]        wr_ptr_q, wr_ptr_d;
    logic [c_fw-1:0]        fill_q, fill_d;
    logic signed [c_sw-1:0] sum_q, sum_d;
    logic signed [WL-1:0]   data_out_q;
    logic                   out_valid_q;
    logic                   win_full_q;

    logic                   w_accept;
    logic                   w_full_now;
    logic [c_pw-1:0]        w_ptr_base;
    logic signed [c_sw-1:0] w_din_ext;
    logic signed [c_sw-1:0] w_old_ext;
    logic signed [WL-1:0]   w_avg;

    assign w_accept   = EN & in_valid;
    assign w_full_now = (fill_q == c_fw'(c_n));
    // A clear coinciding with an accept restarts the window at entry 0.
    assign w_ptr_base = clear ? '0 : wr_ptr_q;
    assign w_din_ext  = c_sw'(data_in);
    assign w_old_ext  = c_sw'(buf_q[wr_ptr_q]);

    always_comb begin
        sum_d    = sum_q;
        fill_d   = fill_q;
        wr_ptr_d = wr_ptr_q;
        if (EN) begin
            if (in_valid) begin
                wr_ptr_d = (w_ptr_base == c_pw'(c_n - 1)) ? '0 : w_ptr_base + c_pw'(1);
                if (clear) begin
                    sum_d  = w_din_ext;
                    fill_d = c_fw'(1);
                end else if (w_full_now) begin
                    sum_d = sum_q + w_din_ext - w_old_ext;
                end else begin
                    sum_d  = sum_q + w_din_ext;
                    fill_d = fill_q + c_fw'(1);
                end
            end else if (clear) begin
                sum_d    = '0;
                fill_d   = '0;
                wr_ptr_d = '0;
            end
        end
    end

`ifdef MOVING_AVG_ROUND_EN
    generate
        if (LOG2_N > 0) begin : g_round
            localparam logic signed [c_sw-1:0] c_half =
                {{(c_sw-1){1'b0}}, 1'b1} << (LOG2_N - 1);
            logic signed [c_sw-1:0] w_rnd;
            logic                   w_unused_lsb;
            assign w_rnd        = sum_d + c_half;
            assign w_avg        = w_rnd[c_sw-1:LOG2_N];
            assign w_unused_lsb = ^w_rnd[LOG2_N-1:0];
        end else begin : g_no_round
            assign w_avg = sum_d[c_sw-1:LOG2_N];
        end
    endgenerate
`else
    // Dropping the low LOG2_N bits of a two's-complement sum is floor division.
    assign w_avg = sum_d[c_sw-1:LOG2_N];
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            sum_q       <= '0;
            fill_q      <= '0;
            wr_ptr_q    <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            win_full_q  <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            fill_q      <= fill_d;
            wr_ptr_q    <= wr_ptr_d;
            out_valid_q <= w_accept;
            win_full_q  <= (fill_d == c_fw'(c_n));
            if (w_accept) begin
                data_out_q <= w_avg;
            end
        end
    end

    // Stale entries are never read: the fill count gates the subtraction.
    always_ff @(posedge CLK) begin
        if (!RST && w_accept) begin
            buf_q[w_ptr_base] <= data_in;
        end
    end

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;
    assign win_full  = win_full_q;

endmodule
`default_nettype wire

// File: tb/tb_moving_avg_win.sv
`default_nettype none
// ============================================================================
// Module   : tb_moving_avg_win
// Brief    : Self-checking bench for moving_avg_win (N=4 and N=1 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_moving_avg_win;

    localparam int WL     = 32;
    localparam int LOG2_N = 2;
    localparam int N      = 1 << LOG2_N;

    logic                 CLK = 1'b0;
    logic                 RST = 1'b1;
    logic                 EN = 1'b0;
    logic                 clear = 1'b0;
    logic                 in_valid = 1'b0;
    logic signed [WL-1:0] data_in = '0;
    logic signed [WL-1:0] data_out, data_out0;
    logic                 out_valid, out_valid0;
    logic                 win_full, win_full0;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: the window is literally the list of retained samples.
    longint m_win[$];
    longint m_out;
    bit     m_valid, m_full;
    longint m_last0;
    bit     m_full0;

    always #5 CLK = ~CLK;

    moving_avg_win #(.WL(WL), .LOG2_N(LOG2_N)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .clear(clear), .in_valid(in_valid),
        .data_in(data_in), .data_out(data_out), .out_valid(out_valid),
        .win_full(win_full)
    );

    moving_avg_win #(.WL(WL), .LOG2_N(0)) dut0 (
        .CLK(CLK), .RST(RST), .EN(EN), .clear(clear), .in_valid(in_valid),
        .data_in(data_in), .data_out(data_out0), .out_valid(out_valid0),
        .win_full(win_full0)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic longint window_avg();
        longint s = 0;
        foreach (m_win[i]) s += m_win[i];
`ifdef MOVING_AVG_ROUND_EN
        s += N / 2;
`endif
        s = s >>> LOG2_N;
        return longint'(int'(s));
    endfunction

    task automatic step(input bit rst, input bit en, input bit clr, input bit v,
                        input int d);
        RST = rst; EN = en; clear = clr; in_valid = v; data_in = d;
        @(posedge CLK);
        #1;
        if (rst) begin
            m_win.delete();
            m_out = 0; m_valid = 0; m_full = 0; m_last0 = 0; m_full0 = 0;
        end else if (!en) begin
            m_valid = 0;
        end else if (v) begin
            if (clr) m_win.delete();
            m_win.push_back(longint'(d));
            if (m_win.size() > N) void'(m_win.pop_front());
            m_out   = window_avg();
            m_valid = 1;
            m_full  = (m_win.size() == N);
            m_last0 = longint'(d);
            m_full0 = 1;
        end else begin
            m_valid = 0;
            if (clr) begin
                m_win.delete();
                m_full = 0; m_full0 = 0;
            end
        end
        check("out_valid", longint'(out_valid), longint'(m_valid));
        check("data_out",  longint'(data_out),  m_out);
        check("win_full",  longint'(win_full),  longint'(m_full));
        check("n1_valid",  longint'(out_valid0), longint'(m_valid));
        check("n1_data",   longint'(data_out0),  m_last0);
        check("n1_full",   longint'(win_full0),  longint'(m_full0));
    endtask

    task automatic accept(input bit clr, input int d);
        step(1'b0, 1'b1, clr, 1'b1, d);
    endtask

    task automatic flush();
        step(1'b0, 1'b1, 1'b1, 1'b0, 0);
    endtask

    int exp_ramp[8];
    longint held;

    initial begin
`ifdef MOVING_AVG_ROUND_EN
        exp_ramp = '{1, 1, 2, 4, 5, 6, 7, 8};
`else
        exp_ramp = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
        step(1'b1, 1'b0, 1'b0, 1'b0, 0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 77);
        check("rst_dout", longint'(data_out), 0);
        check("rst_full", longint'(win_full), 0);

        // Ramp 2..9: fixed expected averages, full after the 4th accept.
        for (int i = 0; i < 8; i++) begin
            accept(1'b0, i + 2);
            check("ramp_dout", longint'(data_out), longint'(exp_ramp[i]));
            check("ramp_full", longint'(win_full), (i >= 3) ? 1 : 0);
        end

        flush();
        for (int i = 0; i < 4; i++) begin
            accept(1'b0, -1);
`ifndef MOVING_AVG_ROUND_EN
            check("neg_dout", longint'(data_out), -1);
`endif
        end
        accept(1'b0, 3);
        check("neg_then3", longint'(data_out), 0);

        // Idle cycles and disabled cycles hold output and fill state.
        held = longint'(data_out);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 55);
        step(1'b0, 1'b0, 1'b1, 1'b1, 99);
        step(1'b0, 1'b0, 1'b0, 1'b1, 98);
        check("en0_hold", longint'(data_out), held);
        check("en0_full", longint'(win_full), 1);
        accept(1'b0, 3);

        flush();
        for (int i = 0; i < 4; i++) accept(1'b0, 4);
        check("clr_pre", longint'(data_out), 4);
        accept(1'b1, 8);
        check("clr_dout", longint'(data_out), 2);
        check("clr_full", longint'(win_full), 0);
        accept(1'b0, 8); check("clr_8a", longint'(data_out), 4);
        accept(1'b0, 8); check("clr_8b", longint'(data_out), 6);
        accept(1'b0, 8); check("clr_8c", longint'(data_out), 8);
        check("clr_full2", longint'(win_full), 1);

        flush();
        accept(1'b0, 100);
        accept(1'b0, -40);
        step(1'b1, 1'b1, 1'b0, 1'b1, 5);
        check("mid_rst_dout", longint'(data_out), 0);
        check("mid_rst_valid", longint'(out_valid), 0);
        accept(1'b0, 12);
        check("post_rst", longint'(data_out), 3);

        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) < 2,
                 $urandom_range(0, 9) != 0,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 9) < 7,
                 int'($urandom()));
        end
        for (int i = 0; i < 200; i++) begin
            step(1'b0, 1'b1, $urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) ? 32'sh7FFF_FFF0 + int'($urandom_range(0, 15))
                                      : -32'sh7FFF_FFF0 - int'($urandom_range(0, 16)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
